// File: rtl/odu_test_gen.sv
// rtl/odu_test_gen.sv - ODU channel test-word generator with incrementing bytes, fs/rs markers and MFAS
module odu_test_gen #(
    parameter int ROW_WORDS = 4,
    parameter int ROWS      = 4,
    parameter int GAP       = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_enable,
    input  logic         i_ready,
    input  logic         i_err_inject,
    output logic [383:0] o_data_chid,
    output logic         o_valid_chid,
    output logic         o_fs_chid,
    output logic         o_rs_chid,
    output logic [7:0]   o_mfas_chid,
    output logic [15:0]  o_word_count,
    output logic [15:0]  o_frame_count
);

    localparam int WW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           rst_meta;
    logic           rst_sync;
    logic [WW-1:0]  word_idx;     // position of the next word to be loaded
    logic [RW-1:0]  row_idx;
    logic [7:0]     seq;
    logic [7:0]     gap_cnt;
    logic           inj_pend;
    logic           first_done;   // first frame after reset keeps MFAS at 0
    logic           accept;
    logic           load;
    logic           gap_start;
    logic           next_fs;
    logic           next_rs;
    logic [383:0]   load_word;

    assign accept  = o_valid_chid & i_ready;
    assign next_rs = (word_idx == '0);
    assign next_fs = next_rs && (row_idx == '0);

    // Reset release synchronizer; assertion stays asynchronous
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // Build the next word from seq, with optional byte-0 corruption
    always_comb begin
        load_word = '0;
        for (int k = 0; k < 48; k++) begin
            load_word[383-8*k -: 8] = seq + 8'(k);
        end
        load_word[383:376] = load_word[383:376] ^ {8{inj_pend}};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and load/gap control; held idle until reset release is synchronized
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        gap_start = 1'b0;
        if (rst_sync) begin
            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        load      = 1'b1;
                        state_nxt = S_SEND;
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        if (next_fs && !i_enable) begin
                            state_nxt = S_IDLE;
                        end else if (GAP > 0) begin
                            gap_start = 1'b1;
                            state_nxt = S_GAP;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt <= 8'd1) begin
                        if (next_fs && !i_enable) begin
                            state_nxt = S_IDLE;
                        end else begin
                            load      = 1'b1;
                            state_nxt = S_SEND;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: word load, position tracking, MFAS, injection and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data_chid   <= '0;
            o_valid_chid  <= 1'b0;
            o_fs_chid     <= 1'b0;
            o_rs_chid     <= 1'b0;
            o_mfas_chid   <= '0;
            o_word_count  <= '0;
            o_frame_count <= '0;
            word_idx      <= '0;
            row_idx       <= '0;
            seq           <= '0;
            gap_cnt       <= '0;
            inj_pend      <= 1'b0;
            first_done    <= 1'b0;
        end else begin
            o_valid_chid <= (state_nxt == S_SEND);
            if (load) begin
                o_data_chid <= load_word;
                o_fs_chid   <= next_fs;
                o_rs_chid   <= next_rs;
                seq         <= seq + 8'd48;
                // a pulse coinciding with a load is kept for the following load
                inj_pend    <= i_err_inject;
                if (next_fs) begin
                    if (first_done) begin
                        o_mfas_chid <= o_mfas_chid + 8'd1;
                    end
                    first_done <= 1'b1;
                end
                if (word_idx == WW'(ROW_WORDS - 1)) begin
                    word_idx <= '0;
                    row_idx  <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
            end else if (rst_sync && i_err_inject) begin
                inj_pend <= 1'b1;
            end
            if (gap_start) begin
                gap_cnt <= 8'(GAP);
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            if (accept) begin
                o_word_count <= o_word_count + 16'd1;
                if (o_fs_chid) begin
                    o_frame_count <= o_frame_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_odu_test_gen.sv
// tb/tb_odu_test_gen.sv - directed self-checking bench for odu_test_gen
module tb_odu_test_gen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en0, rdy0, inj0, en1, rdy1, inj1;
    logic [383:0] data0, data1;
    logic         valid0, fs0, rs0, valid1, fs1, rs1;
    logic [7:0]   mfas0, mfas1;
    logic [15:0]  wc0, fc0, wc1, fc1;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    odu_test_gen #(.ROW_WORDS(2), .ROWS(2), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_enable(en0), .i_ready(rdy0), .i_err_inject(inj0),
        .o_data_chid(data0), .o_valid_chid(valid0), .o_fs_chid(fs0), .o_rs_chid(rs0),
        .o_mfas_chid(mfas0), .o_word_count(wc0), .o_frame_count(fc0)
    );

    odu_test_gen #(.ROW_WORDS(2), .ROWS(2), .GAP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_enable(en1), .i_ready(rdy1), .i_err_inject(inj1),
        .o_data_chid(data1), .o_valid_chid(valid1), .o_fs_chid(fs1), .o_rs_chid(rs1),
        .o_mfas_chid(mfas1), .o_word_count(wc1), .o_frame_count(fc1)
    );

    // expected word: byte k = s + k, byte 0 in the top bits, byte 0 inverted when inj
    function automatic logic [383:0] exp_word(input logic [7:0] s, input logic inj);
        logic [383:0] w;
        logic [7:0]   b;
        w = '0;
        for (int k = 0; k < 48; k++) begin
            b = s + 8'(k);
            if (k == 0 && inj) b = b ^ 8'hFF;
            w = {w[375:0], b};
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_w0(input string tag, input logic [7:0] s, input logic inj,
                          input logic fs, input logic rs, input logic [7:0] mfas);
        chk({tag, "_valid"}, 384'(valid0), 384'(1'b1));
        chk({tag, "_data"}, data0, exp_word(s, inj));
        chk({tag, "_fs"}, 384'(fs0), 384'(fs));
        chk({tag, "_rs"}, 384'(rs0), 384'(rs));
        chk({tag, "_mfas"}, 384'(mfas0), 384'(mfas));
    endtask

    task automatic chk_cnt0(input string tag, input logic [15:0] wc, input logic [15:0] fc);
        chk({tag, "_wcount"}, 384'(wc0), 384'(wc));
        chk({tag, "_fcount"}, 384'(fc0), 384'(fc));
    endtask

    initial begin
        en0 = 1'b0; rdy0 = 1'b1; inj0 = 1'b0;
        en1 = 1'b0; rdy1 = 1'b1; inj1 = 1'b0;
        repeat (3) step();
        chk("rst_valid", 384'(valid0), 384'(1'b0));
        chk("rst_data", data0, '0);
        chk("rst_mfas", 384'(mfas0), '0);
        chk_cnt0("rst", 16'd0, 16'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // continuous stream, enable held
        en0 = 1'b1;
        step(); chk_w0("w0", 8'h00, 1'b0, 1'b1, 1'b1, 8'd0);
        chk_cnt0("w0", 16'd0, 16'd0);
        step(); chk_w0("w1", 8'h30, 1'b0, 1'b0, 1'b0, 8'd0);
        step(); chk_w0("w2", 8'h60, 1'b0, 1'b0, 1'b1, 8'd0);
        step(); chk_w0("w3", 8'h90, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_cnt0("w3", 16'd3, 16'd1);

        // backpressure with an injection pulse while word3 is held
        rdy0 = 1'b0; inj0 = 1'b1;
        step(); inj0 = 1'b0;
        chk_w0("bp1", 8'h90, 1'b0, 1'b0, 1'b0, 8'd0); chk_cnt0("bp1", 16'd3, 16'd1);
        step(); chk_w0("bp2", 8'h90, 1'b0, 1'b0, 1'b0, 8'd0); chk_cnt0("bp2", 16'd3, 16'd1);
        step(); chk_w0("bp3", 8'h90, 1'b0, 1'b0, 1'b0, 8'd0); chk_cnt0("bp3", 16'd3, 16'd1);
        rdy0 = 1'b1;
        step(); chk_w0("w4_inj", 8'hC0, 1'b1, 1'b1, 1'b1, 8'd1);
        chk("w4_byte0", 384'(data0[383:376]), 384'(8'h3F));
        step(); chk_w0("w5_wrap", 8'hF0, 1'b0, 1'b0, 1'b0, 8'd1);
        chk("w5_byte16", 384'(data0[255:248]), 384'(8'h00));
        chk_cnt0("w5", 16'd5, 16'd2);

        // enable dropped mid-frame: frame completes, then idle
        en0 = 1'b0;
        step(); chk_w0("w6", 8'h20, 1'b0, 1'b0, 1'b1, 8'd1);
        step(); chk_w0("w7", 8'h50, 1'b0, 1'b0, 1'b0, 8'd1);
        step(); chk("idle1_valid", 384'(valid0), 384'(1'b0));
        step(); chk("idle2_valid", 384'(valid0), 384'(1'b0));
        chk_cnt0("idle", 16'd8, 16'd2);
        en0 = 1'b1;
        step(); chk_w0("w8_restart", 8'h80, 1'b0, 1'b1, 1'b1, 8'd2);
        step(); chk_w0("w9", 8'hB0, 1'b0, 1'b0, 1'b0, 8'd2);
        step(); chk_w0("w10", 8'hE0, 1'b0, 1'b0, 1'b1, 8'd2);

        // asynchronous reset mid-frame
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 384'(valid0), 384'(1'b0));
        chk("arst_data", data0, '0);
        chk("arst_fs", 384'(fs0), '0);
        chk("arst_rs", 384'(rs0), '0);
        chk("arst_mfas", 384'(mfas0), '0);
        chk_cnt0("arst", 16'd0, 16'd0);
        en0 = 1'b0;
        step(); step();
        rst_n = 1'b1;
        repeat (4) step();
        en0 = 1'b1;
        step(); chk_w0("post_w0", 8'h00, 1'b0, 1'b1, 1'b1, 8'd0);
        chk_cnt0("post_w0", 16'd0, 16'd0);
        step(); chk_w0("post_w1", 8'h30, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_cnt0("post_w1", 16'd1, 16'd1);

        // GAP=2 pattern on the second instance
        en1 = 1'b1;
        step(); chk("g0_valid", 384'(valid1), 384'(1'b1)); chk("g0_data", data1, exp_word(8'h00, 1'b0));
        chk("g0_fs", 384'(fs1), 384'(1'b1));
        step(); chk("g1_valid", 384'(valid1), 384'(1'b0));
        step(); chk("g2_valid", 384'(valid1), 384'(1'b0));
        step(); chk("g3_valid", 384'(valid1), 384'(1'b1)); chk("g3_data", data1, exp_word(8'h30, 1'b0));
        step(); chk("g4_valid", 384'(valid1), 384'(1'b0));
        step(); chk("g5_valid", 384'(valid1), 384'(1'b0));
        step(); chk("g6_valid", 384'(valid1), 384'(1'b1)); chk("g6_data", data1, exp_word(8'h60, 1'b0));
        chk("g6_rs", 384'(rs1), 384'(1'b1));
        chk("g6_wcount", 384'(wc1), 384'(16'd2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
